// File: rtl/ext_pipe.sv
// Pipelined immediate extender with a DEPTH-entry result FIFO and valid/ready handshakes.
// Define EXT_STAT_EN to add the req_cnt/err_cnt request statistics ports.
module ext_pipe #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SHAMT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        EOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext,
    output logic              err
`ifdef EXT_STAT_EN
    ,
    output logic [31:0]       req_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PAD_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_err  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              push, pop;

    logic [DATA_W-1:0] sext, zext, res_data, head_data;
    logic              res_err, head_err;

    // Extension datapath for the incoming request
    always_comb begin
        sext     = {{PAD_W{imm[IMM_W-1]}}, imm};
        zext     = {{PAD_W{1'b0}}, imm};
        res_data = '0;
        res_err  = 1'b0;
        case (EOp)
            3'd0:    res_data = sext;
            3'd1:    res_data = zext;
            3'd2:    res_data = {imm, {PAD_W{1'b0}}};
            3'd3:    res_data = sext << SHAMT;
            3'd4:    res_data = zext << SHAMT;
            default: res_err  = 1'b1;
        endcase
    end

    // Handshake decode, pointer/count update and next head selection
    always_comb begin
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        wr_ptr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt  = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
        // A push landing on the next head slot means the FIFO drains to just this entry
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_data = res_data;
            head_err  = res_err;
        end else begin
            head_data = mem_data[rd_ptr_nxt];
            head_err  = mem_err[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= res_data;
            mem_err[wr_ptr]  <= res_err;
        end
    end

    // Control state plus registered head; ext/err hold their last value when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ext       <= '0;
            err       <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            in_ready  <= (count_nxt < CNT_W'(DEPTH));
            out_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                ext <= head_data;
                err <= head_err;
            end
        end
    end

`ifdef EXT_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt <= '0;
            err_cnt <= '0;
        end else if (push) begin
            req_cnt <= req_cnt + 32'd1;
            if (res_err) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: queue-based reference model checked every cycle,
// plus literal expectations pinning the model at key points.
module tb_ext_pipe;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SHAMT  = 2;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  imm;
    logic [2:0]        EOp;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ext;
    logic              err;
`ifdef EXT_STAT_EN
    logic [31:0]       req_cnt;
    logic [15:0]       err_cnt;
`endif

    ext_pipe #(
        .IMM_W (IMM_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .SHAMT (SHAMT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .imm      (imm),
        .EOp      (EOp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ext      (ext),
        .err      (err)
`ifdef EXT_STAT_EN
        ,
        .req_cnt  (req_cnt),
        .err_cnt  (err_cnt)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;
    int model_pushes = 0;
    int model_errs   = 0;
    bit check_en     = 0;

    logic [DATA_W:0] q[$];
    bit do_push, do_pop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic definition of each extension mode, {err, value}
    function automatic logic [DATA_W:0] model_ext(input logic [IMM_W-1:0] i, input logic [2:0] op);
        longint z, s, r;
        logic   e;
        z = longint'(i);
        s = (z >= (64'sd1 <<< (IMM_W - 1))) ? z - (64'sd1 <<< IMM_W) : z;
        e = 1'b0;
        case (op)
            3'd0:    r = s;
            3'd1:    r = z;
            3'd2:    r = z * (64'sd1 <<< (DATA_W - IMM_W));
            3'd3:    r = s * (64'sd1 <<< SHAMT);
            3'd4:    r = z * (64'sd1 <<< SHAMT);
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, DATA_W'(r)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && out_ready;
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(model_ext(imm, EOp));
                model_pushes = model_pushes + 1;
                if (EOp > 3'd4) model_errs = model_errs + 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            vectors = vectors + 1;
            if (out_valid !== (q.size() != 0)) begin
                miscompares = miscompares + 1;
                $display("FAIL out_valid t=%0t: got %b expected %b", $time, out_valid, q.size() != 0);
            end
            vectors = vectors + 1;
            if (in_ready !== (q.size() < DEPTH)) begin
                miscompares = miscompares + 1;
                $display("FAIL in_ready t=%0t: got %b expected %b", $time, in_ready, q.size() < DEPTH);
            end
            if (q.size() != 0) begin
                vectors = vectors + 1;
                if ({err, ext} !== q[0]) begin
                    miscompares = miscompares + 1;
                    $display("FAIL head t=%0t: got err=%b ext=%h expected err=%b ext=%h",
                             $time, err, ext, q[0][DATA_W], q[0][DATA_W-1:0]);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_one(input logic [IMM_W-1:0] i, input logic [2:0] op,
                            input logic [DATA_W-1:0] exp_ext, input logic exp_err, input string name);
        in_valid = 1'b1; imm = i; EOp = op;
        @(negedge clk);
        in_valid = 1'b0;
        check_lit({name, "_valid"}, 64'(out_valid), 64'd1);
        check_lit({name, "_ext"}, 64'(ext), 64'(exp_ext));
        check_lit({name, "_err"}, 64'(err), 64'(exp_err));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (out_valid) check_lit({name, "_drain_timeout"}, 64'(out_valid), 64'd0);
    endtask

    logic [DATA_W-1:0] s2_exp [4];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; imm = '0; EOp = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_lit("rst_out_valid", 64'(out_valid), 64'd0);
        check_lit("rst_in_ready", 64'(in_ready), 64'd1);
        check_lit("rst_ext", 64'(ext), 64'd0);
        check_lit("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

        // Scenario 1: sign extension
        push_one(16'h0001, 3'd0, 32'h0000_0001, 1'b0, "s1_pos");
        push_one(16'hFFFF, 3'd0, 32'hFFFF_FFFF, 1'b0, "s1_neg");
        @(negedge clk);

        // Scenario 2: back-to-back modes 1..4
        s2_exp[0] = 32'h0000_FFFF; s2_exp[1] = 32'hFFFF_0000;
        s2_exp[2] = 32'hFFFF_FFFC; s2_exp[3] = 32'h0003_FFFC;
        in_valid = 1'b1; imm = 16'hFFFF; EOp = 3'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) EOp = 3'(k + 2);
            else in_valid = 1'b0;
            check_lit($sformatf("s2_valid%0d", k), 64'(out_valid), 64'd1);
            check_lit($sformatf("s2_ext%0d", k), 64'(ext), 64'(s2_exp[k]));
        end
        @(negedge clk);

        // Scenario 3: backpressure with 5 requests
        out_ready = 1'b0;
        EOp = 3'd1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; imm = 16'(16'h0A00 + k);
            @(negedge clk);
        end
        check_lit("s3_full_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!in_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            check_lit("s3_ready_again", 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain("s3");
        @(negedge clk);

        // Scenario 4: full FIFO bubble then steady flow with pointer wrap
        out_ready = 1'b0;
        EOp = 3'd3;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; imm = 16'(16'h8100 + k);
            @(negedge clk);
        end
        imm = 16'h8104;
        out_ready = 1'b1;
        check_lit("s4_bubble_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_lit("s4_after_bubble", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4 * DEPTH; k++) begin
            @(negedge clk);
            imm = imm + 16'd1;
            check_lit($sformatf("s4_steady_ready%0d", k), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        drain("s4");
        @(negedge clk);

        // Scenario 5: illegal opcodes
        push_one(16'h1234, 3'd5, 32'h0, 1'b1, "s5_op5");
        push_one(16'h00FF, 3'd7, 32'h0, 1'b1, "s5_op7");
        @(negedge clk);
`ifdef EXT_STAT_EN
        check_lit("stat_req_cnt", 64'(req_cnt), 64'(model_pushes));
        check_lit("stat_err_cnt", 64'(err_cnt), 64'(model_errs));
`endif

        // Scenario 6: asynchronous reset with queued entries
        out_ready = 1'b0;
        EOp = 3'd1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; imm = 16'(16'h0300 + k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_lit("s6_rst_valid", 64'(out_valid), 64'd0);
        check_lit("s6_rst_ready", 64'(in_ready), 64'd1);
`ifdef EXT_STAT_EN
        check_lit("s6_rst_req_cnt", 64'(req_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_one(16'h8000, 3'd0, 32'hFFFF_8000, 1'b0, "s6_new");
        @(negedge clk);
        check_lit("s6_only_own", 64'(out_valid), 64'd0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
